// File: rtl/prog_load_ctrl.sv
// -----------------------------------------------------------------------------
// prog_load_ctrl
//
// Reloads the PicoBlaze program memory from a byte stream, typically the UART
// receiver. The CPU is held in reset for the whole load. 18-bit instructions
// are assembled from byte triplets and written through the program memory
// write port. The CPU is released once the image has been written and, when
// enabled, validated by a checksum.
//
// Frame: SYNC_BYTE, CNT_HI, CNT_LO, N x (B0, B1, B2) [, CSUM]
//   N           = {CNT_HI[1:0], CNT_LO} + 1   (1..1024)
//   instruction = {B0[1:0], B1, B2}
//   CSUM        = 8-bit sum of all bytes from CNT_HI through the last B2
//
// Build option:
//   PROG_LOAD_CSUM_EN  defined   : the CSUM byte is expected and checked.
//                      undefined : no CSUM state or checksum logic; the CPU
//                                  is released on the cycle after the last
//                                  word's write cycle.
//
// Handshake: rx_valid is a one-cycle strobe; the byte on rx_data is consumed
// in every cycle rx_valid is high. There is no backpressure, so the FSM must
// be ready for a byte on every cycle, including the memory write cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_data/valid   incoming byte stream
//   mem_port_wr     program memory write strobe (one cycle)
//   mem_port_addr   program memory write address
//   mem_port_data   program memory write data
//   cpu_rst         CPU reset, high while loading or after a failed load
//   load_busy       high whenever the FSM is not IDLE
//   load_done       sticky: the last load succeeded
//   load_err        sticky: the last load failed
//   dbg_state       current FSM state encoding (debug/observation)
// -----------------------------------------------------------------------------
module prog_load_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_port_wr,
  output logic [9:0]  mem_port_addr,
  output logic [17:0] mem_port_data,
  output logic        cpu_rst,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err,
  output logic [2:0]  dbg_state
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_B0     = 3'd3,
    S_B1     = 3'd4,
    S_B2     = 3'd5
`ifdef PROG_LOAD_CSUM_EN
    , S_CSUM = 3'd6
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_cnt;
  logic [9:0]    word_last;   // N-1, index of the final word
  logic [9:0]    addr_cnt;    // address of the word being assembled
  logic [9:0]    word_hi;     // {B0[1:0], B1} of the word being assembled
`ifdef PROG_LOAD_CSUM_EN
  logic [7:0]    csum;
`else
  logic          last_wr;     // high during the final word's write cycle
`endif

  logic start, go_err, go_done, wr_word, tmo_hit, is_last;

  assign is_last = (addr_cnt == word_last);
  // Timeout fires on the cycle that would make TIMEOUT_CYCLES idle cycles.
  assign tmo_hit = (state_q != S_IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    go_err  = 1'b0;
    go_done = 1'b0;
    wr_word = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          start   = 1'b1;
          state_d = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (rx_valid) begin
          if (|rx_data[7:2]) go_err = 1'b1;
          else               state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: if (rx_valid) state_d = S_B0;
      S_B0:     if (rx_valid) state_d = S_B1;
      S_B1:     if (rx_valid) state_d = S_B2;
      S_B2: begin
`ifdef PROG_LOAD_CSUM_EN
        if (rx_valid) begin
          wr_word = 1'b1;
          state_d = is_last ? S_CSUM : S_B0;
        end
`else
        // After the final B2 the FSM parks here for the write cycle, then
        // releases the CPU on the following edge.
        if (last_wr) begin
          go_done = 1'b1;
          state_d = S_IDLE;
        end else if (rx_valid) begin
          wr_word = 1'b1;
          state_d = is_last ? S_B2 : S_B0;
        end
`endif
      end
`ifdef PROG_LOAD_CSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum) begin
            go_done = 1'b1;
            state_d = S_IDLE;
          end else begin
            go_err = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      go_err  = 1'b1;
      go_done = 1'b0;
    end
    if (go_err) state_d = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Outputs derived from state
  // ---------------------------------------------------------------------------
  always_comb begin
    load_busy = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath, counters and sticky status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_port_wr   <= 1'b0;
      mem_port_addr <= '0;
      mem_port_data <= '0;
      cpu_rst       <= 1'b0;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      tmo_cnt       <= '0;
      word_last     <= '0;
      addr_cnt      <= '0;
      word_hi       <= '0;
`ifdef PROG_LOAD_CSUM_EN
      csum          <= '0;
`else
      last_wr       <= 1'b0;
`endif
    end else begin
      mem_port_wr <= 1'b0;

      if ((state_q == S_IDLE) || rx_valid) tmo_cnt <= '0;
      else                                 tmo_cnt <= tmo_cnt + 1'b1;

      if (start) begin
        cpu_rst   <= 1'b1;
        load_done <= 1'b0;
        load_err  <= 1'b0;
        addr_cnt  <= '0;
`ifdef PROG_LOAD_CSUM_EN
        csum      <= '0;
`else
        last_wr   <= 1'b0;
`endif
      end

      if (rx_valid) begin
        case (state_q)
          S_CNT_HI: word_last[9:8] <= rx_data[1:0];
          S_CNT_LO: word_last[7:0] <= rx_data;
          S_B0:     word_hi[9:8]   <= rx_data[1:0];
          S_B1:     word_hi[7:0]   <= rx_data;
          default: ;
        endcase
      end

`ifdef PROG_LOAD_CSUM_EN
      // B0[7:2] is discarded for data but still counts toward the checksum.
      if (rx_valid && (state_q inside {S_CNT_HI, S_CNT_LO, S_B0, S_B1, S_B2}))
        csum <= csum + rx_data;
`endif

      if (wr_word) begin
        mem_port_wr   <= 1'b1;
        mem_port_data <= {word_hi, rx_data};
        mem_port_addr <= addr_cnt;
        addr_cnt      <= addr_cnt + 10'd1;
`ifndef PROG_LOAD_CSUM_EN
        last_wr       <= is_last;
`endif
      end

      if (go_err) load_err <= 1'b1;

      if (go_done) begin
        load_done <= 1'b1;
        cpu_rst   <= 1'b0;
`ifndef PROG_LOAD_CSUM_EN
        last_wr   <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_load_ctrl
//
// Directed bench for prog_load_ctrl. Frames are built into a byte queue and
// the expected memory writes ({addr, data}) are pushed into exp_q at build
// time. A monitor pops exp_q on every mem_port_wr pulse; status outputs are
// checked from the stimulus thread at fixed points. Works with or without
// PROG_LOAD_CSUM_EN (the CSUM byte is appended only when it is defined).
// -----------------------------------------------------------------------------
module tb_prog_load_ctrl;

  localparam logic [7:0] SYNC = 8'hA5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        mem_port_wr;
  logic [9:0]  mem_port_addr;
  logic [17:0] mem_port_data;
  logic        cpu_rst, load_busy, load_done, load_err;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  prog_load_ctrl #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .mem_port_wr   (mem_port_wr),
    .mem_port_addr (mem_port_addr),
    .mem_port_data (mem_port_data),
    .cpu_rst       (cpu_rst),
    .load_busy     (load_busy),
    .load_done     (load_done),
    .load_err      (load_err),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [27:0] exp_q[$];
  logic [7:0]  frame_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_wr     = 0;
  logic [9:0]  last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every write pulse must match the head of the expected queue
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && mem_port_wr) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write", mem_port_addr, mem_port_data);
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        if ({mem_port_addr, mem_port_data} === e) n_pass++;
        else $display("FAIL wr: got addr=%0d data=%h, expected addr=%0d data=%h",
                      mem_port_addr, mem_port_data, e[27:18], e[17:0]);
      end
      last_addr = mem_port_addr;
      n_wr++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called in the posedge+1 phase)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    while (frame_q.size() > 0) send_byte(frame_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] word_of(input int i, input int v);
    int t;
    logic [17:0] w;
    t = i * 2654435 + v * 40503 + 17;
    w[7:0]   = i[7:0];
    w[15:8]  = t[15:8];
    w[17:16] = t[1:0];
    return w;
  endfunction

  // Builds a full frame of n words into frame_q and queues the expected writes.
  task automatic build_frame(input int n, input int v, input bit bad);
    logic [9:0]  nm1;
    logic [7:0]  s, hi, lo, b0, b1, b2;
    logic [17:0] w;
    nm1 = 10'(n - 1);
    hi  = {6'b0, nm1[9:8]};
    lo  = nm1[7:0];
    frame_q.push_back(SYNC);
    frame_q.push_back(hi);
    frame_q.push_back(lo);
    s = hi + lo;
    for (int i = 0; i < n; i++) begin
      w  = word_of(i, v);
      b0 = {6'(i + v), w[17:16]};
      b1 = w[15:8];
      b2 = w[7:0];
      frame_q.push_back(b0);
      frame_q.push_back(b1);
      frame_q.push_back(b2);
      s = s + b0 + b1 + b2;
      exp_q.push_back({10'(i), w});
    end
    if (bad) s = s + 8'd1;
`ifdef PROG_LOAD_CSUM_EN
    frame_q.push_back(s);
`endif
  endtask

  task automatic check_released(input string tag);
    check({tag, "_done"},    {31'b0, load_done}, 32'd1);
    check({tag, "_cpu_rst"}, {31'b0, cpu_rst},   32'd0);
    check({tag, "_err"},     {31'b0, load_err},  32'd0);
    check({tag, "_busy"},    {31'b0, load_busy}, 32'd0);
    check({tag, "_pending"}, exp_q.size(),       32'd0);
  endtask

  // Watchdog: a hang is reported as a failure.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset values
    check("rst_wr",    {31'b0, mem_port_wr},    32'd0);
    check("rst_addr",  {22'b0, mem_port_addr},  32'd0);
    check("rst_data",  {14'b0, mem_port_data},  32'd0);
    check("rst_cpu",   {31'b0, cpu_rst},        32'd0);
    check("rst_busy",  {31'b0, load_busy},      32'd0);
    check("rst_done",  {31'b0, load_done},      32'd0);
    check("rst_err",   {31'b0, load_err},       32'd0);
    check("rst_state", {29'b0, dbg_state},      32'd0);

    // Valid 2-word load from the hand-computed vector
    send_byte(SYNC);
    check("t1_cpu_rst_held", {31'b0, cpu_rst},   32'd1);
    check("t1_busy",         {31'b0, load_busy}, 32'd1);
    exp_q.push_back({10'd0, 18'h2ABCD});
    exp_q.push_back({10'd1, 18'h00001});
    frame_q.push_back(8'h00); frame_q.push_back(8'h01);
    frame_q.push_back(8'h02); frame_q.push_back(8'hAB); frame_q.push_back(8'hCD);
    frame_q.push_back(8'h00); frame_q.push_back(8'h00); frame_q.push_back(8'h01);
`ifdef PROG_LOAD_CSUM_EN
    frame_q.push_back(8'h7C);
`endif
    send_frame();
    idle(2);
    check_released("t1");

`ifdef PROG_LOAD_CSUM_EN
    // Bad checksum: writes still happen, CPU stays in reset
    exp_q.push_back({10'd0, 18'h2ABCD});
    exp_q.push_back({10'd1, 18'h00001});
    frame_q.push_back(SYNC);
    frame_q.push_back(8'h00); frame_q.push_back(8'h01);
    frame_q.push_back(8'h02); frame_q.push_back(8'hAB); frame_q.push_back(8'hCD);
    frame_q.push_back(8'h00); frame_q.push_back(8'h00); frame_q.push_back(8'h01);
    frame_q.push_back(8'h7D);
    send_frame();
    idle(1);
    check("csum_err",     {31'b0, load_err},  32'd1);
    check("csum_cpu_rst", {31'b0, cpu_rst},   32'd1);
    check("csum_done",    {31'b0, load_done}, 32'd0);
    check("csum_pending", exp_q.size(),       32'd0);
`endif

    // Single-word frame (N=1 boundary) releases the CPU
    build_frame(1, 4, 1'b0);
    send_frame();
    idle(2);
    check_released("n1");

    // Non-sync bytes in IDLE are ignored, then a bad header
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    check("ign_busy", {31'b0, load_busy}, 32'd0);
    check("ign_done", {31'b0, load_done}, 32'd1);
    send_byte(SYNC);
    send_byte(8'h04);
    check("hdr_err",   {31'b0, load_err},  32'd1);
    check("hdr_busy",  {31'b0, load_busy}, 32'd0);
    check("hdr_state", {29'b0, dbg_state}, 32'd0);
    check("hdr_cpu",   {31'b0, cpu_rst},   32'd1);
    check("hdr_done",  {31'b0, load_done}, 32'd0);
    idle(2);

    // Timeout after CNT_HI
    send_byte(SYNC);
    send_byte(8'h00);
    idle(90);
    check("tmo_early_err",  {31'b0, load_err},  32'd0);
    check("tmo_early_busy", {31'b0, load_busy}, 32'd1);
    idle(15);
    check("tmo_err",  {31'b0, load_err},  32'd1);
    check("tmo_busy", {31'b0, load_busy}, 32'd0);
    check("tmo_cpu",  {31'b0, cpu_rst},   32'd1);

    // 1024-word frame, bytes back-to-back across every word boundary
    n_wr = 0;
    build_frame(1024, 7, 1'b0);
    send_frame();
    idle(2);
    check_released("big");
    check("big_wr_count",  n_wr,                 32'd1024);
    check("big_last_addr", {22'b0, last_addr},   32'd1023);

    // Reset in the middle of a 10-word load after 3 words
    exp_q.push_back({10'd0, word_of(0, 9)});
    exp_q.push_back({10'd1, word_of(1, 9)});
    exp_q.push_back({10'd2, word_of(2, 9)});
    send_byte(SYNC); send_byte(8'h00); send_byte(8'h09);
    for (int i = 0; i < 3; i++) begin
      logic [17:0] w;
      w = word_of(i, 9);
      send_byte({6'b0, w[17:16]});
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    idle(1);
    check("mid_pending", exp_q.size(), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_wr",    {31'b0, mem_port_wr},   32'd0);
    check("mid_addr",  {22'b0, mem_port_addr}, 32'd0);
    check("mid_data",  {14'b0, mem_port_data}, 32'd0);
    check("mid_cpu",   {31'b0, cpu_rst},       32'd0);
    check("mid_busy",  {31'b0, load_busy},     32'd0);
    check("mid_done",  {31'b0, load_done},     32'd0);
    check("mid_err",   {31'b0, load_err},      32'd0);
    check("mid_state", {29'b0, dbg_state},     32'd0);

    // Full reload after the mid-load reset starts again at address 0
    build_frame(3, 11, 1'b0);
    send_frame();
    idle(2);
    check_released("reload");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Sequences PicoBlaze program-memory reloads from a byte stream, e.g. the UART receiver.
- Holds the CPU in reset while loading.
- Assembles 18-bit instructions from byte triplets and drives the program memory write port (mem_port_wr/addr/data).
- Releases the CPU once the image has been written and validated.
- Sits between the RX byte source and the CPU/program-memory unit; the integrator ties the memory write clock to clk.

Parameters:
- SYNC_BYTE, 8'hA5, header byte that starts a load.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between accepted bytes during a load.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; the byte on rx_data is accepted that cycle. There is no backpressure.
- mem_port_wr  out  1  program memory write strobe, one cycle wide.
- mem_port_addr  out  10  program memory write address.
- mem_port_data  out  18  program memory write data.
- cpu_rst  out  1  reset to the CPU, active high.
- load_busy  out  1  high while in any state other than IDLE.
- load_done  out  1  sticky: the last load succeeded.
- load_err  out  1  sticky: the last load failed.

Behaviour:
- Reset values: mem_port_wr=0, mem_port_addr=0, mem_port_data=0, cpu_rst=0, load_busy=0, load_done=0, load_err=0; state=IDLE. After reset the CPU runs its existing image.
- Frame format: SYNC_BYTE, CNT_HI, CNT_LO, N×(B0,B1,B2), CSUM.
  - Word count N = {CNT_HI[1:0],CNT_LO}+1, range 1..1024.
  - Each instruction = {B0[1:0],B1,B2}.
  - CSUM = 8-bit modulo sum of every byte from CNT_HI through the last B2.
- States: IDLE, CNT_HI, CNT_LO, B0, B1, B2, CSUM.
- IDLE:
  - Bytes other than SYNC_BYTE are ignored.
  - On SYNC_BYTE, at the next edge: cpu_rst=1, load_done=0, load_err=0, address counter=0, checksum=0, go to CNT_HI.
- CNT_HI:
  - If byte[7:2]≠0, go to error.
  - Otherwise latch byte[1:0], add it to the checksum, go to CNT_LO.
- CNT_LO: latch, add to the checksum, go to B0.
- B0/B1/B2:
  - Each accepted byte is shifted into the word register and added to the checksum.
  - B0[7:2] is ignored for data but is included in the checksum.
- Word write on accepting B2:
  - Next cycle: mem_port_wr=1, mem_port_data=assembled word, mem_port_addr=current address.
  - The address increments after the write cycle.
  - The FSM goes directly to B0, or to CSUM if this was word N, so a byte arriving in the write cycle is not lost.
- A SYNC_BYTE value mid-frame is plain data; there is no escaping.
- CSUM:
  - If the byte equals the running sum: load_done=1, cpu_rst=0 next cycle, go to IDLE.
  - Otherwise, go to error.
- Error (any cause): load_err=1, cpu_rst stays 1, go to IDLE. Only a later successful load releases the CPU.
- Timeout:
  - The counter runs in all non-IDLE states and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES, go to error.
- Address wrap: impossible, since N≤1024 and the last write is at 1023.
- rst mid-load: immediately returns to reset values, including cpu_rst=0. Words already written are left in memory; the integrator must not reset mid-load without reloading.
- Latency: the last write occurs 1 cycle after B2 is accepted. cpu_rst falls 1 cycle after a valid CSUM is accepted.

Optional Feature:
- Macro PROG_LOAD_CSUM_EN.
- Defined: CSUM byte is expected and checked as above.
- Undefined:
  - CSUM state and checksum logic are removed.
  - After word N's write cycle: load_done=1, cpu_rst=0, return to IDLE.
  - load_err can then only come from a CNT_HI format error or a timeout.

Test Plan:
- Valid 2-word load, CSUM_EN defined: bytes A5 00 01 02 AB CD 00 00 01 7C.
  - Writes (addr 0, 18'h2ABCD) and (addr 1, 18'h00001).
  - load_done=1, cpu_rst 1→0, load_err=0.
- Same frame with CSUM 7D → both writes occur, load_err=1, cpu_rst remains 1, load_done=0. A following valid frame releases cpu_rst.
- Bad header: A5 04 → load_err=1, no mem_port_wr pulses, state IDLE.
- Timeout (TIMEOUT_CYCLES=100 on the bench): A5 00 then idle for 100 cycles → load_err=1, busy=0, cpu_rst=1.
- Back-to-back bytes: rx_valid on consecutive cycles across word boundaries for a 1024-word frame. Every address 0..1023 is written exactly once and there is no dropped byte; the last address is 1023.
- Mid-load rst after 3 words → all outputs at reset values. A subsequent full frame reloads from address 0.
